// File: rtl/ped_request.sv
// ped_request: pedestrian-request front end for a two-approach intersection.
//
// Each approach has its own channel: 2-flop synchroniser, tick-based
// debouncer, rising-edge press detector, and a request FSM (IDLE, PENDING,
// LOCKOUT) that holds the request until the light controller grants it. The
// FSM then ignores new presses for a lockout window. The WAIT indicator is
// driven high on entry to PENDING and toggles every FLASH_TICKS ticks while
// the request is pending.
//
// Handshake: req is a level. The controller may pulse grant (one cycle) only
// once it has seen req high. The channel drops req on the next edge, so a
// grant while req is low has no effect.
//
// Ports:
//   clk        in  system clock, rising edge
//   rst        in  synchronous active-high reset
//   tick       in  one-cycle time-base enable; all tick timing uses it
//   day_night  in  1 = day operation, 0 = night flashing (cancels requests)
//   btn1/btn2  in  raw asynchronous push-buttons, active-high
//   grant1/2   in  one-cycle grant pulses from the light controller
//   req1/req2  out request pending for approach 1/2
//   wait_led1/2 out flashing WAIT indicator for approach 1/2

module ped_request_chan #(
    parameter int unsigned DEB_TICKS   = 20,
    parameter int unsigned LOCK_TICKS  = 100,
    parameter int unsigned FLASH_TICKS = 250
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic day_night,
    input  logic btn,
    input  logic grant,
    output logic req,
    output logic wait_led
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        LOCKOUT = 2'd2
    } state_t;

    localparam logic [15:0] DEB_MAX   = 16'(DEB_TICKS);
    localparam logic [15:0] LOCK_MAX  = 16'(LOCK_TICKS);
    localparam logic [15:0] FLASH_MAX = 16'(FLASH_TICKS);

    logic        sync1_q, btn_s_q;
    logic        btn_db_q, btn_db_d;
    logic        btn_db_prev_q;
    logic [15:0] deb_cnt_q, deb_cnt_d;
    state_t      state_q, state_d;
    logic [15:0] lock_cnt_q, lock_cnt_d;
    logic [15:0] flash_cnt_q, flash_cnt_d;
    logic        wait_q, wait_d;
    logic        press;

    // Debouncer: count ticks while the synchronised level disagrees with
    // the debounced level; any agreement restarts the count.
    always_comb begin
        deb_cnt_d = deb_cnt_q;
        btn_db_d  = btn_db_q;
        if (btn_s_q == btn_db_q) begin
            deb_cnt_d = 16'd0;
        end else if (tick) begin
            if (deb_cnt_q + 16'd1 == DEB_MAX) begin
                btn_db_d  = btn_s_q;
                deb_cnt_d = 16'd0;
            end else begin
                deb_cnt_d = deb_cnt_q + 16'd1;
            end
        end
    end

    // Only a rising edge of the debounced level counts as a press.
    assign press = btn_db_q & ~btn_db_prev_q;

    always_comb begin
        state_d     = state_q;
        lock_cnt_d  = lock_cnt_q;
        flash_cnt_d = flash_cnt_q;
        wait_d      = wait_q;
        unique case (state_q)
            IDLE: begin
                wait_d = 1'b0;
                // A grant is meaningless here; a press (day only) wins.
                if (press && day_night) begin
                    state_d     = PENDING;
                    wait_d      = 1'b1;
                    flash_cnt_d = 16'd0;
                end
            end
            PENDING: begin
                // Grant takes priority over a night cancel in the same cycle.
                if (grant) begin
                    state_d    = LOCKOUT;
                    lock_cnt_d = 16'd0;
                    wait_d     = 1'b0;
                end else if (!day_night) begin
                    state_d = IDLE;
                    wait_d  = 1'b0;
                end else if (tick) begin
                    if (flash_cnt_q + 16'd1 == FLASH_MAX) begin
                        wait_d      = ~wait_q;
                        flash_cnt_d = 16'd0;
                    end else begin
                        flash_cnt_d = flash_cnt_q + 16'd1;
                    end
                end
            end
            LOCKOUT: begin
                // Lockout keeps counting even at night.
                wait_d = 1'b0;
                if (tick) begin
                    if (lock_cnt_q + 16'd1 == LOCK_MAX) begin
                        state_d    = IDLE;
                        lock_cnt_d = 16'd0;
                    end else begin
                        lock_cnt_d = lock_cnt_q + 16'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                wait_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q       <= 1'b0;
            btn_s_q       <= 1'b0;
            btn_db_q      <= 1'b0;
            btn_db_prev_q <= 1'b0;
            deb_cnt_q     <= 16'd0;
            state_q       <= IDLE;
            lock_cnt_q    <= 16'd0;
            flash_cnt_q   <= 16'd0;
            wait_q        <= 1'b0;
        end else begin
            sync1_q       <= btn;
            btn_s_q       <= sync1_q;
            btn_db_q      <= btn_db_d;
            btn_db_prev_q <= btn_db_q;
            deb_cnt_q     <= deb_cnt_d;
            state_q       <= state_d;
            lock_cnt_q    <= lock_cnt_d;
            flash_cnt_q   <= flash_cnt_d;
            wait_q        <= wait_d;
        end
    end

    assign req      = (state_q == PENDING);
    assign wait_led = wait_q;

endmodule

module ped_request #(
    parameter int unsigned DEB_TICKS   = 20,
    parameter int unsigned LOCK_TICKS  = 100,
    parameter int unsigned FLASH_TICKS = 250
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic day_night,
    input  logic btn1,
    input  logic btn2,
    input  logic grant1,
    input  logic grant2,
    output logic req1,
    output logic req2,
    output logic wait_led1,
    output logic wait_led2
);

    ped_request_chan #(
        .DEB_TICKS  (DEB_TICKS),
        .LOCK_TICKS (LOCK_TICKS),
        .FLASH_TICKS(FLASH_TICKS)
    ) u_ch1 (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .day_night(day_night),
        .btn      (btn1),
        .grant    (grant1),
        .req      (req1),
        .wait_led (wait_led1)
    );

    ped_request_chan #(
        .DEB_TICKS  (DEB_TICKS),
        .LOCK_TICKS (LOCK_TICKS),
        .FLASH_TICKS(FLASH_TICKS)
    ) u_ch2 (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .day_night(day_night),
        .btn      (btn2),
        .grant    (grant2),
        .req      (req2),
        .wait_led (wait_led2)
    );

endmodule

// File: doc/ped_request.md
# ped_request

Pedestrian-request front end for the two-approach intersection controller. Synchronises and debounces the two raw pedestrian push-buttons and latches each press into a held request. The request stays held until the light controller grants it, after which a lockout window applies. Drives a flashing "WAIT" indicator per approach while a request is pending. Sits directly upstream of the light controller; its `req1`/`req2` outputs feed the controller's mode sequencing, and the controller's `grant1`/`grant2` pulses come back into this block.

## Interface
- `DEB_TICKS`, 20: consecutive `tick` pulses a synchronised button level must hold before the debounced level changes (1..65535).
- `LOCK_TICKS`, 100: `tick` pulses after a grant during which new presses on that approach are ignored (1..65535).
- `FLASH_TICKS`, 250: `tick` pulses per half-period of the WAIT indicator (1..65535).
- `clk` in 1: system clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `tick` in 1: single-cycle time-base enable from the frequency divider; all tick-counted timing advances only on cycles with `tick`=1.
- `day_night` in 1: 1 = day operation, 0 = night flashing mode.
- `btn1` in 1: raw pedestrian button, approach 1; asynchronous, active-high.
- `btn2` in 1: raw pedestrian button, approach 2; asynchronous, active-high.
- `grant1` in 1: one-cycle pulse from the controller accepting the approach-1 request.
- `grant2` in 1: one-cycle pulse from the controller accepting the approach-2 request.
- `req1` out 1: approach-1 request pending; held high until granted or cancelled.
- `req2` out 1: approach-2 request pending; same rules.
- `wait_led1` out 1: approach-1 WAIT indicator.
- `wait_led2` out 1: approach-2 WAIT indicator.

## Operation
- The two channels are identical and fully independent. The rules below apply to channel n.
- **Synchroniser:** `btnn` passes through a 2-flop synchroniser to give `btn_sn`. Both flops reset to 0.
- **Debounce:** 16-bit counter `deb_cnt`.
  - If `btn_sn` equals the debounced level `btn_dbn`, `deb_cnt` is cleared to 0.
  - Otherwise, on `tick`, `deb_cnt` increments. When it reaches `DEB_TICKS`, `btn_dbn` takes `btn_sn` and `deb_cnt` clears.
  - `btn_dbn` resets to 0.
- **Press event:** `press` = `btn_dbn` & ~`btn_dbn_d` (rising edge of the debounced level). A release generates no event.
- **Request FSM** (states IDLE, PENDING, LOCKOUT; reset state IDLE):
  - IDLE: if `press` & `day_night` -> PENDING. A press while `day_night`=0 is discarded. `grant` is ignored.
  - PENDING: `req`=1.
    - `grant` -> LOCKOUT, with lock counter loaded to 0.
    - Else if `day_night`=0 -> IDLE (request cancelled).
    - Further presses have no effect.
  - LOCKOUT: on each `tick` the lock counter increments. When it reaches `LOCK_TICKS` -> IDLE. Presses and grants are ignored.
    - If `day_night`=0, stay and keep counting.
- **Outputs:**
  - `req` = (state == PENDING), registered.
  - `wait_led` = 0 outside PENDING.
  - On entry to PENDING, `wait_led` = 1 and the flash counter = 0. On each `tick` in PENDING the flash counter increments. When it reaches `FLASH_TICKS`, `wait_led` toggles and the counter clears.
- **Simultaneous events:**
  - `press` and `grant` in the same cycle in IDLE: the press wins (-> PENDING).
  - `grant` and `day_night` falling in the same cycle in PENDING: the grant wins (-> LOCKOUT).
- **Reset:** `rst` mid-operation returns all state to reset values on the next edge, regardless of `tick`. Reset values: `req1`=`req2`=0, `wait_led1`=`wait_led2`=0, all counters 0.

## Timing
- Button to `btn_sn`: 2 clk.
- `btn_sn` change to `btn_dbn` change: takes effect at the clk edge of the `DEB_TICKS`-th qualifying `tick` after the change.
- `btn_dbn` rising to `req` high: 1 clk (the edge after `btn_dbn` rises).
- `grant` to `req` low: `req` is low on the edge following the grant cycle. `wait_led` falls on the same edge.
- LOCKOUT exit: IDLE at the edge of the `LOCK_TICKS`-th `tick` after the grant. A press detected on the following cycle is accepted.
- The controller must hold its grant sampling until `req` is seen high. `grant` while `req`=0 is a no-op.
- Any `btn` glitch shorter than `DEB_TICKS` ticks produces no `press`.

## Test plan
- **Basic request:** `DEB_TICKS`=3, `tick`=1, `day_night`=1; raise `btn1` and hold -> `req1` rises exactly 6 clk after `btn1`, and `wait_led1` is 1 on the same edge; `req2` stays 0.
- **Glitch rejection:** `btn1` high for 2 clk, then low (`DEB_TICKS`=3, `tick`=1) -> `req1` never asserts and the debounced level stays 0.
- **Grant and lockout:** pending `req1`; pulse `grant1` -> `req1`=0 and `wait_led1`=0 next clk. A new press within `LOCK_TICKS`=10 ticks is ignored. A press after the lockout ends sets `req1` again.
- **Flashing:** `FLASH_TICKS`=4, `tick`=1, PENDING -> `wait_led1` pattern is 1111 0000 1111 from the entry edge.
- **Night cancel:** `req2` pending; drop `day_night` -> `req2`=0 next clk. A press with `day_night`=0 leaves `req2`=0.
- **Simultaneous events and reset:** press and `grant1` in the same cycle in IDLE -> PENDING. Assert `rst` mid-lockout while `tick`=0 -> all outputs 0 next edge; a subsequent press is accepted without lockout.
